// File: rtl/hood_mode_scheduler.sv
// hood_mode_scheduler: range-hood mode FSM. Decodes one-cycle button pulses
// into fan levels, self-clean and a level-3 exit countdown, and keeps the
// seconds countdown for every timed mode. All outputs come straight from flops.
module hood_mode_scheduler #(
  parameter int unsigned TICKS_PER_SEC = 100_000_000,
  parameter int unsigned L3_SEC        = 60,
  parameter int unsigned EXIT_SEC      = 60,
  parameter int unsigned CLEAN_SEC     = 180
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       machine_state,
  input  logic       menu_btn,
  input  logic       level1_btn,
  input  logic       level2_btn,
  input  logic       level3_btn,
  input  logic       clean_btn,
  output logic [2:0] mode,
  output logic [1:0] fan_level,
  output logic [7:0] remaining_sec,
  output logic       l3_used,
  output logic       clean_done
);

  localparam int unsigned      CNT_W      = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CNT_W-1:0] TICK_MAX   = CNT_W'(TICKS_PER_SEC - 1);
  localparam logic [7:0]       L3_SEC_V   = 8'(L3_SEC);
  localparam logic [7:0]       EXIT_SEC_V = 8'(EXIT_SEC);
  localparam logic [7:0]       CLEAN_SEC_V = 8'(CLEAN_SEC);

  typedef enum logic [2:0] {
    MODE_OFF     = 3'd0,
    MODE_STANDBY = 3'd1,
    MODE_MENU    = 3'd2,
    MODE_L1      = 3'd3,
    MODE_L2      = 3'd4,
    MODE_L3      = 3'd5,
    MODE_L3_EXIT = 3'd6,
    MODE_CLEAN   = 3'd7
  } mode_t;

  typedef enum logic [2:0] {
    BTN_NONE  = 3'd0,
    BTN_MENU  = 3'd1,
    BTN_CLEAN = 3'd2,
    BTN_L3    = 3'd3,
    BTN_L2    = 3'd4,
    BTN_L1    = 3'd5
  } btn_t;

  mode_t            mode_r;
  mode_t            mode_nxt_s;
  logic [1:0]       fan_r;
  logic [1:0]       fan_nxt_s;
  logic [7:0]       rem_r;
  logic [7:0]       rem_nxt_s;
  logic             used_r;
  logic             used_nxt_s;
  logic             done_r;
  logic             done_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  btn_t             btn_s;
  logic             timed_s;
  logic             tick_s;
  logic             expire_s;
  logic             enter_s;

  // Modes whose duration is bounded by the seconds countdown.
  function automatic logic is_timed(input mode_t m);
    return (m == MODE_L3) || (m == MODE_L3_EXIT) || (m == MODE_CLEAN);
  endfunction

  // Fan speed shown for a given mode.
  function automatic logic [1:0] fan_for(input mode_t m);
    case (m)
      MODE_L1:      return 2'd1;
      MODE_L2:      return 2'd2;
      MODE_L3:      return 2'd3;
      MODE_L3_EXIT: return 2'd3;
      default:      return 2'd0;
    endcase
  endfunction

  // Pick the single winning button: menu > clean > level3 > level2 > level1.
  always_comb begin
    btn_s = BTN_NONE;
    if (menu_btn) begin
      btn_s = BTN_MENU;
    end else if (clean_btn) begin
      btn_s = BTN_CLEAN;
    end else if (level3_btn) begin
      btn_s = BTN_L3;
    end else if (level2_btn) begin
      btn_s = BTN_L2;
    end else if (level1_btn) begin
      btn_s = BTN_L1;
    end else begin
      btn_s = BTN_NONE;
    end
  end

  // Next mode: power loss first, then countdown expiry, then the winning button.
  always_comb begin
    mode_nxt_s = mode_r;
    timed_s    = is_timed(mode_r);
    tick_s     = timed_s && (cnt_r == TICK_MAX);
    expire_s   = tick_s && (rem_r <= 8'd1);
    if (!machine_state) begin
      mode_nxt_s = MODE_OFF;
    end else begin
      case (mode_r)
        MODE_OFF: mode_nxt_s = MODE_STANDBY;
        MODE_STANDBY: begin
          if (btn_s == BTN_MENU) mode_nxt_s = MODE_MENU;
          else                   mode_nxt_s = mode_r;
        end
        MODE_MENU: begin
          case (btn_s)
            BTN_MENU:  mode_nxt_s = MODE_STANDBY;
            BTN_CLEAN: mode_nxt_s = MODE_CLEAN;
            BTN_L3:    mode_nxt_s = used_r ? mode_r : MODE_L3;
            BTN_L2:    mode_nxt_s = MODE_L2;
            BTN_L1:    mode_nxt_s = MODE_L1;
            default:   mode_nxt_s = mode_r;
          endcase
        end
        MODE_L1, MODE_L2: begin
          case (btn_s)
            BTN_MENU: mode_nxt_s = MODE_STANDBY;
            BTN_L3:   mode_nxt_s = used_r ? mode_r : MODE_L3;
            BTN_L2:   mode_nxt_s = MODE_L2;
            BTN_L1:   mode_nxt_s = MODE_L1;
            default:  mode_nxt_s = mode_r;
          endcase
        end
        MODE_L3: begin
          if (expire_s)                mode_nxt_s = MODE_L2;
          else if (btn_s == BTN_MENU)  mode_nxt_s = MODE_L3_EXIT;
          else                         mode_nxt_s = mode_r;
        end
        MODE_L3_EXIT, MODE_CLEAN: begin
          if (expire_s) mode_nxt_s = MODE_STANDBY;
          else          mode_nxt_s = mode_r;
        end
        default: mode_nxt_s = MODE_STANDBY;
      endcase
    end
  end

  // Datapath next values: tick counter, seconds left, level-3 latch, clean pulse.
  always_comb begin
    enter_s    = (mode_nxt_s != mode_r);
    cnt_nxt_s  = {CNT_W{1'b0}};
    rem_nxt_s  = 8'd0;
    fan_nxt_s  = fan_for(mode_nxt_s);
    done_nxt_s = machine_state && (mode_r == MODE_CLEAN) && expire_s;

    // A fresh timed mode restarts the sub-second count so its first second is full.
    if (is_timed(mode_nxt_s) && !enter_s) begin
      if (tick_s) cnt_nxt_s = {CNT_W{1'b0}};
      else        cnt_nxt_s = cnt_r + CNT_W'(1);
    end else begin
      cnt_nxt_s = {CNT_W{1'b0}};
    end

    case (mode_nxt_s)
      MODE_L3:      rem_nxt_s = enter_s ? L3_SEC_V    : (tick_s ? rem_r - 8'd1 : rem_r);
      MODE_L3_EXIT: rem_nxt_s = enter_s ? EXIT_SEC_V  : (tick_s ? rem_r - 8'd1 : rem_r);
      MODE_CLEAN:   rem_nxt_s = enter_s ? CLEAN_SEC_V : (tick_s ? rem_r - 8'd1 : rem_r);
      default:      rem_nxt_s = 8'd0;
    endcase

    if (!machine_state) begin
      used_nxt_s = 1'b0;
    end else if (enter_s && (mode_nxt_s == MODE_L3)) begin
      used_nxt_s = 1'b1;
    end else begin
      used_nxt_s = used_r;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_r <= MODE_OFF;
      fan_r  <= 2'd0;
      rem_r  <= 8'd0;
      used_r <= 1'b0;
      done_r <= 1'b0;
      cnt_r  <= {CNT_W{1'b0}};
    end else begin
      mode_r <= mode_nxt_s;
      fan_r  <= fan_nxt_s;
      rem_r  <= rem_nxt_s;
      used_r <= used_nxt_s;
      done_r <= done_nxt_s;
      cnt_r  <= cnt_nxt_s;
    end
  end

  assign mode          = mode_r;
  assign fan_level     = fan_r;
  assign remaining_sec = rem_r;
  assign l3_used       = used_r;
  assign clean_done    = done_r;

endmodule

// File: tb/tb_hood_mode_scheduler.sv
// Testbench for hood_mode_scheduler: a vector table for the basic mode walk,
// hand sequences for timed corners, then random pulses against a
// deadline-based reference model.
module tb_hood_mode_scheduler;

  localparam int TPS = 4;
  localparam int L3S = 3;
  localparam int EXS = 2;
  localparam int CLS = 5;

  // Button vectors ordered {menu, clean, level3, level2, level1}.
  localparam logic [4:0] B_NONE  = 5'b00000;
  localparam logic [4:0] B_MENU  = 5'b10000;
  localparam logic [4:0] B_CLEAN = 5'b01000;
  localparam logic [4:0] B_L3    = 5'b00100;
  localparam logic [4:0] B_L2    = 5'b00010;
  localparam logic [4:0] B_L1    = 5'b00001;

  logic       clk = 1'b0;
  logic       rst;
  logic       machine_state;
  logic       menu_btn, level1_btn, level2_btn, level3_btn, clean_btn;
  logic [2:0] mode;
  logic [1:0] fan_level;
  logic [7:0] remaining_sec;
  logic       l3_used;
  logic       clean_done;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic       ms;
    logic [4:0] btn;
    int         md;
    int         fan;
    int         rem;
    int         used;
    int         done;
  } vec_t;

  vec_t vecs[$];

  // Reference model state: mode number, absolute expiry cycle, level-3 latch.
  int m_mode, m_deadline, m_used, m_done, m_cyc;

  hood_mode_scheduler #(
    .TICKS_PER_SEC(TPS), .L3_SEC(L3S), .EXIT_SEC(EXS), .CLEAN_SEC(CLS)
  ) dut (
    .clk(clk), .rst(rst), .machine_state(machine_state),
    .menu_btn(menu_btn), .level1_btn(level1_btn), .level2_btn(level2_btn),
    .level3_btn(level3_btn), .clean_btn(clean_btn),
    .mode(mode), .fan_level(fan_level), .remaining_sec(remaining_sec),
    .l3_used(l3_used), .clean_done(clean_done)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int md, input int fn, input int rm,
                         input int us, input int dn);
    chk($sformatf("%s mode", tag), int'(mode), md);
    chk($sformatf("%s fan", tag), int'(fan_level), fn);
    chk($sformatf("%s rem", tag), int'(remaining_sec), rm);
    chk($sformatf("%s l3_used", tag), int'(l3_used), us);
    chk($sformatf("%s clean_done", tag), int'(clean_done), dn);
  endtask

  // Apply inputs for one clock edge, then release the pulses; outputs are stable after return.
  task automatic drive(input logic ms, input logic [4:0] b);
    machine_state = ms;
    {menu_btn, clean_btn, level3_btn, level2_btn, level1_btn} = b;
    @(posedge clk);
    #1;
    {menu_btn, clean_btn, level3_btn, level2_btn, level1_btn} = 5'b00000;
  endtask

  function automatic vec_t mkv(input logic ms, input logic [4:0] b, input int md,
                               input int fn, input int rm, input int us, input int dn);
    vec_t v;
    v.ms = ms; v.btn = b; v.md = md; v.fan = fn; v.rem = rm; v.used = us; v.done = dn;
    return v;
  endfunction

  function automatic int secs_of(input int md);
    case (md)
      5:       return L3S;
      6:       return EXS;
      7:       return CLS;
      default: return 0;
    endcase
  endfunction

  function automatic int fan_of(input int md);
    case (md)
      3:       return 1;
      4:       return 2;
      5, 6:    return 3;
      default: return 0;
    endcase
  endfunction

  function automatic int m_rem();
    if (m_mode >= 5) return (m_deadline - m_cyc + TPS - 1) / TPS;
    return 0;
  endfunction

  task automatic m_enter(input int md);
    m_mode = md;
    m_deadline = m_cyc + secs_of(md) * TPS;
    if (md == 5) m_used = 1;
  endtask

  // Advance the model by one clock edge with the given inputs.
  task automatic model_edge(input logic ms, input logic [4:0] b);
    int w;
    m_cyc++;
    m_done = 0;
    w = b[4] ? 1 : b[3] ? 2 : b[2] ? 3 : b[1] ? 4 : b[0] ? 5 : 0;
    if (!ms) begin
      m_mode = 0;
      m_used = 0;
    end else if (m_mode >= 5 && m_cyc == m_deadline) begin
      m_done = (m_mode == 7) ? 1 : 0;
      m_mode = (m_mode == 5) ? 4 : 1;
    end else begin
      case (m_mode)
        0: m_mode = 1;
        1: if (w == 1) m_mode = 2;
        2: case (w)
             1: m_mode = 1;
             2: m_enter(7);
             3: if (m_used == 0) m_enter(5);
             4: m_mode = 4;
             5: m_mode = 3;
             default: ;
           endcase
        3, 4: case (w)
             1: m_mode = 1;
             3: if (m_used == 0) m_enter(5);
             4: m_mode = 4;
             5: m_mode = 3;
             default: ;
           endcase
        5: if (w == 1) m_enter(6);
        default: ;
      endcase
    end
  endtask

  initial begin
    logic       ms_r;
    logic [4:0] b_r;
    logic [14:0] act_v, exp_v;

    rst = 1'b0;
    machine_state = 1'b0;
    {menu_btn, clean_btn, level3_btn, level2_btn, level1_btn} = 5'b00000;

    // Basic walk: standby/menu/levels, priority, L3 countdown and expiry.
    vecs.push_back(mkv(1'b1, B_NONE,  1, 0, 0, 0, 0));
    vecs.push_back(mkv(1'b1, B_MENU,  2, 0, 0, 0, 0));
    vecs.push_back(mkv(1'b1, B_L2,    4, 2, 0, 0, 0));
    vecs.push_back(mkv(1'b1, B_L1,    3, 1, 0, 0, 0));
    vecs.push_back(mkv(1'b1, B_L2,    4, 2, 0, 0, 0));
    vecs.push_back(mkv(1'b1, B_CLEAN, 4, 2, 0, 0, 0));
    vecs.push_back(mkv(1'b1, B_MENU,  1, 0, 0, 0, 0));
    vecs.push_back(mkv(1'b1, B_L2,    1, 0, 0, 0, 0));
    vecs.push_back(mkv(1'b1, B_MENU,  2, 0, 0, 0, 0));
    vecs.push_back(mkv(1'b1, B_MENU | B_L2, 1, 0, 0, 0, 0));
    vecs.push_back(mkv(1'b1, B_MENU,  2, 0, 0, 0, 0));
    vecs.push_back(mkv(1'b1, B_L3,    5, 3, 3, 1, 0));
    vecs.push_back(mkv(1'b1, B_NONE,  5, 3, 3, 1, 0));
    vecs.push_back(mkv(1'b1, B_L1,    5, 3, 3, 1, 0));
    vecs.push_back(mkv(1'b1, B_NONE,  5, 3, 3, 1, 0));
    for (int i = 4; i < 8; i++) vecs.push_back(mkv(1'b1, B_NONE, 5, 3, 2, 1, 0));
    vecs.push_back(mkv(1'b1, B_CLEAN, 5, 3, 1, 1, 0));
    for (int i = 9; i < 12; i++) vecs.push_back(mkv(1'b1, B_NONE, 5, 3, 1, 1, 0));
    vecs.push_back(mkv(1'b1, B_MENU,  4, 2, 0, 1, 0));
    vecs.push_back(mkv(1'b1, B_L3,    4, 2, 0, 1, 0));
    vecs.push_back(mkv(1'b1, B_L1,    3, 1, 0, 1, 0));
    vecs.push_back(mkv(1'b1, B_L3,    3, 1, 0, 1, 0));
    vecs.push_back(mkv(1'b1, B_MENU,  1, 0, 0, 1, 0));
    vecs.push_back(mkv(1'b1, B_MENU,  2, 0, 0, 1, 0));
    vecs.push_back(mkv(1'b1, B_L3,    2, 0, 0, 1, 0));
    vecs.push_back(mkv(1'b1, B_MENU,  1, 0, 0, 1, 0));

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0, 0, 0, 0, 0);
    #2 rst = 1'b1;
    drive(1'b0, B_NONE);
    chk_all("off_hold", 0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].ms, vecs[i].btn);
      chk_all($sformatf("vec%0d", i), vecs[i].md, vecs[i].fan, vecs[i].rem,
              vecs[i].used, vecs[i].done);
    end

    // Power cycle re-arms level 3; menu in L3 starts the exit countdown.
    drive(1'b0, B_NONE);
    chk_all("pwr_off", 0, 0, 0, 0, 0);
    drive(1'b1, B_NONE);
    chk_all("pwr_on", 1, 0, 0, 0, 0);
    drive(1'b1, B_MENU);
    drive(1'b1, B_L3);
    chk_all("l3_again", 5, 3, 3, 1, 0);
    repeat (4) drive(1'b1, B_NONE);
    chk_all("l3_4cyc", 5, 3, 2, 1, 0);
    drive(1'b1, B_MENU);
    chk_all("exit_entry", 6, 3, 2, 1, 0);
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, (i % 2 == 1) ? B_L1 : B_L3);
      if (i < 8) chk_all($sformatf("exit%0d", i), 6, 3, (i < 4) ? 2 : 1, 1, 0);
      else       chk_all("exit_done", 1, 0, 0, 1, 0);
    end

    // Full clean run with a one-cycle done pulse; menu on the expiry edge is dropped.
    drive(1'b1, B_MENU);
    drive(1'b1, B_CLEAN);
    chk_all("clean_entry", 7, 0, 5, 1, 0);
    for (int i = 1; i <= 20; i++) begin
      drive(1'b1, (i == 10 || i == 20) ? B_MENU : B_NONE);
      if (i < 20) chk_all($sformatf("clean%0d", i), 7, 0, 5 - i / 4, 1, 0);
      else        chk_all("clean_done", 1, 0, 0, 1, 1);
    end
    drive(1'b1, B_NONE);
    chk_all("done_once", 1, 0, 0, 1, 0);

    // Power loss mid-clean: straight to OFF, no done pulse.
    drive(1'b1, B_MENU);
    drive(1'b1, B_CLEAN);
    repeat (8) drive(1'b1, B_NONE);
    chk_all("clean_mid", 7, 0, 3, 1, 0);
    drive(1'b0, B_NONE);
    chk_all("clean_pwroff", 0, 0, 0, 0, 0);
    drive(1'b0, B_NONE);
    chk_all("clean_off2", 0, 0, 0, 0, 0);
    drive(1'b1, B_NONE);
    chk_all("repower", 1, 0, 0, 0, 0);
    drive(1'b1, B_MENU);
    drive(1'b1, B_L3);
    chk_all("l3_rearmed", 5, 3, 3, 1, 0);

    // Asynchronous reset in the middle of L3 clears outputs before any edge.
    drive(1'b1, B_NONE);
    drive(1'b1, B_NONE);
    chk("pre_rst mode", int'(mode), 5);
    #2 rst = 1'b0;
    #1;
    chk_all("async_rst", 0, 0, 0, 0, 0);
    @(posedge clk);
    #1 rst = 1'b1;

    // Random pulses against the deadline-based model.
    m_mode = 0; m_used = 0; m_done = 0; m_cyc = 0; m_deadline = 0;
    for (int i = 0; i < 4000; i++) begin
      ms_r = ($urandom_range(99, 0) >= 2);
      for (int k = 0; k < 5; k++) b_r[k] = ($urandom_range(99, 0) < 6);
      drive(ms_r, b_r);
      model_edge(ms_r, b_r);
      act_v = {mode, fan_level, remaining_sec, l3_used, clean_done};
      exp_v = {3'(m_mode), 2'(fan_of(m_mode)), 8'(m_rem()), 1'(m_used), 1'(m_done)};
      chk($sformatf("rand%0d {mode,fan,rem,used,done}", i), int'(act_v), int'(exp_v));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hood_mode_scheduler.md
Name: hood_mode_scheduler

Overview:
- Sequences the range-hood fan and cleaning resource once the power controller reports the machine on.
- Accepts debounced one-cycle button pulses and walks a mode FSM: standby, menu, fan levels 1/2/3, level-3 exit countdown, self-clean.
- Owns all timed mode transitions with a seconds countdown.
- Drives fan_level for the motor/display path and remaining_sec for the display path.

Parameters:
- TICKS_PER_SEC, 100_000_000, clk cycles per second tick
- L3_SEC, 60, level-3 run time before automatic fallback to level 2
- EXIT_SEC, 60, countdown after menu pressed in level 3, before standby
- CLEAN_SEC, 180, self-clean duration

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- machine_state  in  1  power state from on/off controller; 1 = on
- menu_btn  in  1  one-cycle pulse
- level1_btn  in  1  one-cycle pulse
- level2_btn  in  1  one-cycle pulse
- level3_btn  in  1  one-cycle pulse
- clean_btn  in  1  one-cycle pulse
- mode  out  3  OFF=0, STANDBY=1, MENU=2, L1=3, L2=4, L3=5, L3_EXIT=6, CLEAN=7
- fan_level  out  2  0 = stopped, 1..3 = fan speed
- remaining_sec  out  8  seconds left in the timed mode; 0 when untimed
- l3_used  out  1  level 3 already consumed this power-on
- clean_done  out  1  one-cycle pulse when clean completes

Behaviour:
- Reset (rst=0, async): mode=OFF, fan_level=0, remaining_sec=0, l3_used=0, clean_done=0, tick counter=0.
- All outputs are registered. A button pulse at edge N changes mode and fan_level at edge N+1 (1-cycle latency).
- machine_state=0 has top priority in any state:
  - next edge goes to OFF; fan_level=0, remaining_sec=0, tick counter=0, l3_used=0.
  - No clean_done pulse is issued.
- OFF -> STANDBY on the first edge with machine_state=1.
- STANDBY, fan 0: menu -> MENU. All other buttons are ignored.
- MENU, fan 0:
  - level1 -> L1; level2 -> L2.
  - level3 -> L3 only if l3_used=0; otherwise ignored.
  - clean -> CLEAN.
  - menu -> STANDBY.
- L1 / L2, fan 1 / 2:
  - level1 or level2 switches directly between L1 and L2.
  - level3 -> L3 if l3_used=0.
  - menu -> STANDBY.
  - clean is ignored.
- L3, fan 3:
  - On entry: l3_used<=1, remaining_sec<=L3_SEC.
  - On expiry -> L2.
  - menu -> L3_EXIT with remaining_sec<=EXIT_SEC. All other buttons are ignored.
- L3_EXIT, fan 3: all buttons are ignored. On expiry -> STANDBY.
- CLEAN, fan 0: remaining_sec<=CLEAN_SEC on entry; all buttons are ignored. On expiry -> STANDBY with a clean_done pulse for exactly 1 cycle.
- Timing:
  - The tick counter counts 0..TICKS_PER_SEC-1 only in timed states (L3, L3_EXIT, CLEAN).
  - It is cleared to 0 on every timed-state entry, so the first second is full length.
  - At the count TICKS_PER_SEC-1, remaining_sec decrements.
  - Expiry occurs when remaining_sec=1 and a tick fires: the state changes on that same edge and remaining_sec becomes 0.
  - In untimed states remaining_sec=0 and the counter is held at 0.
- Button priority when several pulse in one cycle: menu > clean > level3 > level2 > level1. Only the winner is evaluated; if it is ignored in the current state, nothing happens.
- Expiry and a button on the same edge: expiry wins and the button is dropped.
- remaining_sec is wide enough for values up to 255. Parameters above 255 are illegal.
- No unreachable state: any illegal mode encoding recovers to STANDBY if machine_state=1, else OFF.

Test Plan:
(Bench parameters: TICKS_PER_SEC=4, L3_SEC=3, EXIT_SEC=2, CLEAN_SEC=5.)
- Reset, then machine_state=1 -> mode=1, fan_level=0. Then menu, level2 -> mode=4, fan=2 one cycle after each pulse. Then level1 -> mode=3, fan=1.
- MENU, level3 -> mode=5, fan=3, remaining_sec=3, l3_used=1. Then 12 cycles -> mode=4 (L2), fan=2, remaining_sec=0. Second level3 -> mode stays 4.
- In L3 after 4 cycles (remaining=2), menu -> mode=6, remaining=2, fan=3. Then 8 cycles -> mode=1, fan=0. level1 pulses during L3_EXIT have no effect.
- MENU, clean -> mode=7, remaining 5,4,3,2,1 every 4 cycles. On cycle 20: mode=1 with clean_done=1 for exactly one cycle.
- Mid-CLEAN (remaining=3), machine_state=0 -> next cycle mode=0, remaining=0, no clean_done. Power back on -> STANDBY, l3_used=0, and level 3 is allowed again.
- Simultaneous menu+level2 in MENU -> mode=1 (menu wins). rst asserted mid-L3 -> outputs zero immediately, without waiting for a clk edge.
